// File: rtl/rgmii_delay_calib.sv
// rgmii_delay_calib
// -----------------
// Sweeps the RGMII receive IDELAY tap from 0 to 31 and finds the longest run
// of consecutive taps on which the receive checker reports no errors. The
// final tap is placed at the centre of that run. If no run reaches
// MIN_WINDOW taps, DEFAULT_TAP is applied and cal_fail is raised.
//
// Per tap: LOAD (1 cycle, tap_load strobe), SETTLE (SETTLE_CYCLES cycles),
// MEASURE (until SAMPLES_PER_TAP qualified samples or TIMEOUT_CYCLES cycles),
// NEXT (1 cycle, run tracking update).
//
// Handshake: start is a single-cycle request sampled on the clock edge. It is
// honoured only while the block is idle or done, and is ignored while busy.
// tap_load is a one-cycle strobe that marks the cycle in which tap_value
// changes. sample_err is only looked at in cycles where sample_valid is high.
//
// Ports
//   delay_clk     in   IDELAYCTRL reference clock, clocks all logic
//   delay_rst_n   in   asynchronous active-low reset
//   idelay_rdy    in   IDELAYCTRL ready; losing it restarts the sweep
//   start         in   calibration request
//   sample_valid  in   one qualified receive-check result
//   sample_err    in   that result failed
//   tap_value     out  IDELAY tap for RXD[3:0] and RCTL
//   tap_load      out  strobe: tap_value is new this cycle
//   busy          out  calibration running
//   done          out  calibration finished (held until next start)
//   cal_fail      out  no window of MIN_WINDOW taps found
//   window_len    out  length of the chosen passing window
//   dbg_state     out  current FSM state, for observation only
module rgmii_delay_calib #(
    parameter int SETTLE_CYCLES   = 64,
    parameter int SAMPLES_PER_TAP = 16,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int DEFAULT_TAP     = 25,
    parameter int MIN_WINDOW      = 3
) (
    input  logic       delay_clk,
    input  logic       delay_rst_n,
    input  logic       idelay_rdy,
    input  logic       start,
    input  logic       sample_valid,
    input  logic       sample_err,
    output logic [4:0] tap_value,
    output logic       tap_load,
    output logic       busy,
    output logic       done,
    output logic       cal_fail,
    output logic [5:0] window_len,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_MEASURE, S_NEXT, S_FINISH, S_DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  tap_q, cur_start_q, best_start_q, tap_value_q;
    logic [5:0]  cur_len_q, best_len_q, window_len_q;
    logic [31:0] settle_cnt_q, sample_cnt_q, timeout_cnt_q;
    logic        tap_fail_q, tap_load_q, busy_q, done_q, cal_fail_q;

    // Run tracking as it will look after the NEXT cycle for the current tap.
    logic [5:0]  cur_len_d, best_len_d, centre_d;
    logic [4:0]  cur_start_d, best_start_d, final_tap_d;
    logic        final_fail_d;
    logic [31:0] sample_cnt_d;
    logic        meas_done, meas_timeout, in_sweep;

    always_comb begin
        cur_len_d    = 6'd0;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (!tap_fail_q) begin
            cur_len_d = cur_len_q + 6'd1;
            if (cur_len_q == 6'd0) cur_start_d = tap_q;
            // Strict compare keeps the earliest window on a tie.
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
        end
        // Centre of the window, rounding toward the lower tap.
        centre_d     = {1'b0, best_start_d} + ((best_len_d - 6'd1) >> 1);
        final_fail_d = (best_len_d < 6'(MIN_WINDOW));
        final_tap_d  = final_fail_d ? 5'(DEFAULT_TAP) : centre_d[4:0];

        sample_cnt_d = sample_cnt_q + {31'd0, sample_valid};
        meas_done    = (sample_cnt_d >= 32'(SAMPLES_PER_TAP));
        meas_timeout = (timeout_cnt_q >= 32'(TIMEOUT_CYCLES - 1));
        in_sweep     = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                       (state_q == S_MEASURE) || (state_q == S_NEXT);
    end

    always_ff @(posedge delay_clk or negedge delay_rst_n) begin
        if (!delay_rst_n) begin
            state_q       <= S_IDLE;
            tap_q         <= 5'd0;
            cur_start_q   <= 5'd0;
            best_start_q  <= 5'd0;
            cur_len_q     <= 6'd0;
            best_len_q    <= 6'd0;
            settle_cnt_q  <= 32'd0;
            sample_cnt_q  <= 32'd0;
            timeout_cnt_q <= 32'd0;
            tap_fail_q    <= 1'b0;
            tap_value_q   <= 5'(DEFAULT_TAP);
            tap_load_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cal_fail_q    <= 1'b0;
            window_len_q  <= 6'd0;
        end else begin
            tap_load_q <= 1'b0;
            if (in_sweep && !idelay_rdy) begin
                // Delay line lost lock: everything measured so far is suspect.
                state_q       <= S_WAIT_RDY;
                tap_q         <= 5'd0;
                cur_start_q   <= 5'd0;
                best_start_q  <= 5'd0;
                cur_len_q     <= 6'd0;
                best_len_q    <= 6'd0;
                settle_cnt_q  <= 32'd0;
                sample_cnt_q  <= 32'd0;
                timeout_cnt_q <= 32'd0;
                tap_fail_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state_q      <= S_WAIT_RDY;
                            tap_q        <= 5'd0;
                            cur_start_q  <= 5'd0;
                            best_start_q <= 5'd0;
                            cur_len_q    <= 6'd0;
                            best_len_q   <= 6'd0;
                            tap_fail_q   <= 1'b0;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                            cal_fail_q   <= 1'b0;
                            window_len_q <= 6'd0;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (idelay_rdy) begin
                            state_q     <= S_LOAD;
                            tap_value_q <= tap_q;
                            tap_load_q  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state_q      <= S_SETTLE;
                        settle_cnt_q <= 32'd0;
                    end
                    S_SETTLE: begin
                        if (settle_cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                            state_q       <= S_MEASURE;
                            sample_cnt_q  <= 32'd0;
                            timeout_cnt_q <= 32'd0;
                            tap_fail_q    <= 1'b0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 32'd1;
                        end
                    end
                    S_MEASURE: begin
                        sample_cnt_q  <= sample_cnt_d;
                        timeout_cnt_q <= timeout_cnt_q + 32'd1;
                        if (sample_valid && sample_err) tap_fail_q <= 1'b1;
                        // A full sample set wins over a timeout in the same cycle.
                        if (meas_done) begin
                            state_q <= S_NEXT;
                        end else if (meas_timeout) begin
                            state_q    <= S_NEXT;
                            tap_fail_q <= 1'b1;
                        end
                    end
                    S_NEXT: begin
                        cur_len_q    <= cur_len_d;
                        cur_start_q  <= cur_start_d;
                        best_len_q   <= best_len_d;
                        best_start_q <= best_start_d;
                        tap_load_q   <= 1'b1;
                        if (tap_q == 5'd31) begin
                            state_q      <= S_FINISH;
                            tap_value_q  <= final_tap_d;
                            cal_fail_q   <= final_fail_d;
                            window_len_q <= best_len_d;
                        end else begin
                            state_q     <= S_LOAD;
                            tap_q       <= tap_q + 5'd1;
                            tap_value_q <= tap_q + 5'd1;
                        end
                    end
                    S_FINISH: begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tap_value  = tap_value_q;
    assign tap_load   = tap_load_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cal_fail   = cal_fail_q;
    assign window_len = window_len_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rgmii_delay_calib.sv
// Bench for rgmii_delay_calib: a channel model answers each tap with pass or
// fail from a per-tap mask, a scoreboard checks the sequence of tap loads,
// and a reference model derives the expected window from the mask.
module tb_rgmii_delay_calib;

    localparam int SETTLE  = 4;
    localparam int SAMPLES = 4;
    localparam int TMO     = 100;
    localparam int DEF_TAP = 25;
    localparam int MIN_W   = 3;
    localparam int PERIOD  = 1 + SETTLE + SAMPLES + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_err = 1'b0;
    logic [4:0] tap_value;
    logic       tap_load, busy, done, cal_fail;
    logic [5:0] window_len;
    logic [2:0] dbg_state;

    rgmii_delay_calib #(
        .SETTLE_CYCLES(SETTLE), .SAMPLES_PER_TAP(SAMPLES), .TIMEOUT_CYCLES(TMO),
        .DEFAULT_TAP(DEF_TAP), .MIN_WINDOW(MIN_W)
    ) dut (
        .delay_clk(clk), .delay_rst_n(rst_n), .idelay_rdy(rdy), .start(start),
        .sample_valid(sample_valid), .sample_err(sample_err),
        .tap_value(tap_value), .tap_load(tap_load), .busy(busy), .done(done),
        .cal_fail(cal_fail), .window_len(window_len), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- channel model / driver ----------------
    logic [31:0] pass_mask = '0;
    int          drv_mode  = 0;   // 0: no samples, 1: valid every cycle, 2: random
    bit          garbage   = 0;   // drive failing samples during LOAD/SETTLE
    int          cur_tap   = 0;
    int          since     = 1000;

    always @(negedge clk) begin
        if (rst_n && tap_load) begin
            cur_tap = int'(tap_value);
            since   = 0;
        end else if (since < 1000) begin
            since++;
        end
        if (drv_mode == 0) begin
            sample_valid = 1'b0;
            sample_err   = 1'b0;
        end else if (garbage && since <= SETTLE) begin
            sample_valid = 1'b1;
            sample_err   = 1'b1;
        end else begin
            sample_valid = (drv_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (sample_valid) sample_err = !pass_mask[cur_tap];
            else              sample_err = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard on tap loads ----------------
    logic [4:0] exp_q[$];
    bit         chk_interval = 0;
    bit         have_last    = 0;
    int         cyc = 0;
    int         last_cyc = 0;

    always @(negedge clk) begin
        logic [4:0] e;
        cyc++;
        if (rst_n && tap_load) begin
            check("load_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("load_tap", 32'(tap_value), 32'(e));
            end
            if (chk_interval) begin
                if (have_last) check("tap_period", 32'(cyc - last_cyc), 32'(PERIOD));
                have_last = 1;
                last_cyc  = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [31:0] mask, output int wlen,
                                      output int tap, output int fail);
        int best = 0;
        int bs   = 0;
        for (int s = 0; s < 32; s++) begin
            bit is_start;
            int l;
            is_start = mask[s] && ((s == 0) ? 1'b1 : !mask[s-1]);
            if (is_start) begin
                l = 0;
                while (s + l < 32 && mask[s+l] == 1'b1) l++;
                if (l > best) begin
                    best = l;
                    bs   = s;
                end
            end
        end
        wlen = best;
        fail = (best < MIN_W) ? 1 : 0;
        tap  = fail ? DEF_TAP : bs + (best - 1) / 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic fill_sweep(input logic [4:0] final_tap);
        for (int t = 0; t < 32; t++) exp_q.push_back(5'(t));
        exp_q.push_back(final_tap);
    endtask

    task automatic start_cal();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 6000) begin
            step(1);
            n++;
        end
        check({tag, "_done_reached"}, 32'(done), 32'd1);
    endtask

    task automatic wait_tap(input int t, input int s);
        int n = 0;
        while (!(cur_tap == t && since == s && busy) && n < 6000) begin
            step(1);
            n++;
        end
        check("reach_tap", 32'(cur_tap), 32'(t));
    endtask

    task automatic check_result(input string tag, input logic [31:0] mask);
        int wl, tp, fl;
        ref_model(mask, wl, tp, fl);
        wait_done(tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_window_len"}, 32'(window_len), 32'(wl));
        check({tag, "_tap_value"}, 32'(tap_value), 32'(tp));
        check({tag, "_cal_fail"}, 32'(cal_fail), 32'(fl));
        step(5);
        check({tag, "_hold_tap"}, 32'(tap_value), 32'(tp));
        check({tag, "_hold_done"}, 32'(done), 32'd1);
        check({tag, "_loads_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_cal(input string tag, input logic [31:0] mask, input int mode,
                           input bit garb, input bit interval);
        int wl, tp, fl;
        ref_model(mask, wl, tp, fl);
        pass_mask    = mask;
        drv_mode     = mode;
        garbage      = garb;
        chk_interval = interval;
        have_last    = 0;
        fill_sweep(5'(tp));
        start_cal();
        check_result(tag, mask);
        chk_interval = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] m;
        int          wl, tp, fl;

        step(3);
        check("rst_tap_value", 32'(tap_value), 32'(DEF_TAP));
        check("rst_tap_load", 32'(tap_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cal_fail", 32'(cal_fail), 32'd0);
        check("rst_window_len", 32'(window_len), 32'd0);
        rst_n = 1'b1;
        step(3);
        check("idle_no_busy", 32'(busy), 32'd0);

        // Every tap clean, samples each cycle, junk during settle.
        run_cal("all_pass", 32'hFFFF_FFFF, 1, 1, 1);

        // Two windows; longest one wins.
        run_cal("two_win", (32'h7FF << 10) | (32'h7 << 25), 2, 0, 0);

        // Equal windows; the lower one wins.
        run_cal("tie", (32'hF << 4) | (32'hF << 20), 2, 1, 0);

        // Only runs of two: below the minimum window.
        run_cal("short", 32'hC000_0063, 2, 0, 0);

        // Equal minimum windows at both ends of the range.
        run_cal("edges", 32'hE000_0007, 2, 0, 0);

        // Random channel masks.
        for (int i = 0; i < 3; i++) begin
            m = $urandom() | $urandom();
            run_cal("random", m, 2, 0, 0);
        end

        // Ready lost while measuring tap 12: sweep restarts at tap 0.
        m = (32'h7FF << 10) | (32'h7 << 25);
        ref_model(m, wl, tp, fl);
        pass_mask = m;
        drv_mode  = 2;
        garbage   = 0;
        for (int t = 0; t <= 12; t++) exp_q.push_back(5'(t));
        fill_sweep(5'(tp));
        start_cal();
        wait_tap(12, SETTLE + 2);
        rdy = 1'b0;
        step(3);
        check("rdy_drop_busy", 32'(busy), 32'd1);
        check("rdy_drop_no_done", 32'(done), 32'd0);
        step(47);
        rdy = 1'b1;
        check_result("rdy_drop", m);

        // Start while measuring is ignored; reset during tap 8 discards the run.
        pass_mask = 32'hFFFF_FFFF;
        drv_mode  = 2;
        fill_sweep(5'd15);
        start_cal();
        wait_tap(3, SETTLE + 2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_tap(8, SETTLE + 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tap_value", 32'(tap_value), 32'(DEF_TAP));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_tap_load", 32'(tap_load), 32'd0);
        check("mid_rst_loads_seen", 32'(exp_q.size()), 32'd24);
        exp_q.delete();
        step(3);
        rst_n = 1'b1;
        step(20);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_tap_value", 32'(tap_value), 32'(DEF_TAP));

        // No samples at all: every tap times out.
        run_cal("timeout", 32'h0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgmii_delay_calib.md
RGMII_DELAY_CALIB -- requirements
Module: rgmii_delay_calib

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64: delay_clk cycles to wait after each tap load before sampling.
REQ-002 SHALL have parameter SAMPLES_PER_TAP, default 16: qualified samples evaluated per tap.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles spent in MEASURE per tap.
REQ-004 SHALL have parameter DEFAULT_TAP, default 25: tap used after reset and on calibration failure.
REQ-005 SHALL have parameter MIN_WINDOW, default 3: minimum passing-window length for success.
REQ-006 delay_clk  in  1  single clock for all logic; the IDELAYCTRL reference clock.
REQ-007 delay_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 idelay_rdy  in  1  IDELAYCTRL RDY, synchronous to delay_clk.
REQ-009 start  in  1  one-cycle calibration request.
REQ-010 sample_valid  in  1  one qualified receive-check result this cycle.
REQ-011 sample_err  in  1  result failed; meaningful only with sample_valid.
REQ-012 tap_value  out  5  IDELAY tap applied to RXD[3:0] and RCTL lanes.
REQ-013 tap_load  out  1  one-cycle strobe; tap_value is new this cycle.
REQ-014 busy  out  1  calibration in progress.
REQ-015 done  out  1  calibration finished; held until next accepted start.
REQ-016 cal_fail  out  1  no window >= MIN_WINDOW found; valid while done.
REQ-017 window_len  out  6  length of the selected passing window (0..32).

Function
REQ-018 FSM states SHALL be IDLE, WAIT_RDY, LOAD, SETTLE, MEASURE, NEXT, FINISH, DONE.
REQ-019 start SHALL be accepted only in IDLE or DONE; on acceptance: go to WAIT_RDY, tap counter=0, clear done/cal_fail/run tracking, busy=1 next cycle; start while busy SHALL be ignored.
REQ-020 WAIT_RDY SHALL stay until idelay_rdy=1, then go to LOAD.
REQ-021 LOAD SHALL last one cycle: tap_value=tap counter, tap_load=1; then SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, ignoring sample inputs; then MEASURE.
REQ-023 MEASURE SHALL count sample_valid cycles; tap fails if any sample_valid&&sample_err; leave after SAMPLES_PER_TAP samples or TIMEOUT_CYCLES cycles, whichever first; timeout marks tap failed.
REQ-024 NEXT (one cycle) SHALL update tracking: pass -> if cur_len==0 then cur_start=tap; cur_len+=1; if cur_len>best_len (strict) then best_len=cur_len, best_start=cur_start; fail -> cur_len=0.
REQ-025 NEXT SHALL go to FINISH if tap==31, else tap+=1 and go to LOAD; tap counter SHALL never wrap.
REQ-026 FINISH (one cycle) SHALL drive tap_value=best_start+((best_len-1)>>1) if best_len>=MIN_WINDOW, else tap_value=DEFAULT_TAP and cal_fail=1; tap_load=1; window_len=best_len.
REQ-027 DONE SHALL hold done=1, busy=0, tap_value stable, no tap_load until start.
REQ-028 Ties SHALL resolve to the earliest (lowest-tap) window.
REQ-029 idelay_rdy=0 in LOAD/SETTLE/MEASURE/NEXT SHALL abort to WAIT_RDY, reset tap counter to 0 and run tracking; busy stays 1.
REQ-030 Total cycles per tap with clean samples SHALL be 1 (LOAD)+SETTLE_CYCLES+measure cycles+1 (NEXT).

Reset
REQ-031 delay_rst_n=0 SHALL immediately force IDLE, tap_value=DEFAULT_TAP, tap_load=0, busy=0, done=0, cal_fail=0, window_len=0, all counters and tracking cleared.
REQ-032 Reset mid-calibration SHALL discard all results; no tap_load on reset release.

Verification
REQ-033 All 32 taps pass -> tap_load 32 times + final, window_len=32, tap_value=15, cal_fail=0.
REQ-034 Taps 10..20 and 25..27 pass -> window_len=11, tap_value=15.
REQ-035 Taps 4..7 and 20..23 pass -> earliest wins, window_len=4, tap_value=5.
REQ-036 No sample_valid ever (TIMEOUT_CYCLES=100) -> every tap times out, cal_fail=1, tap_value=25, window_len=0.
REQ-037 idelay_rdy dropped during tap 12 MEASURE, restored 50 cycles later -> WAIT_RDY, next tap_load carries tap_value=0, final result equals undisturbed run.
REQ-038 start during MEASURE ignored; delay_rst_n low during tap 8 -> tap_value=25, busy=0, done=0 immediately.
